rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter. Shares one resource between requesters 0..3 and drives a one-hot grant bus.
- The winning index is decoded to one-hot by the team's existing 2-to-4 decoder. This block adds the sequencing: priority rotation, hold/release handshake, hold timeout and a turnaround cycle.
- Sits in front of any shared datapath selected by a one-hot enable.

Parameters:
- MAX_HOLD, 16: maximum consecutive GRANT cycles per owner; 0 disables the timeout.
- CNT_W, 5: hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: arbitration enable; low blocks new grants only.
- req, input, 4: request bits; req[i] is level-held by requester i while it wants the resource.
- done, input, 1: owner's release strobe; only meaningful in GRANT.
- grant, output, 4: one-hot grant, or 0000.
- grant_id, output, 2: index of the current/last owner.
- busy, output, 1: high in GRANT.
- timeout, output, 1: one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset, applied synchronously when rst=1 at an edge:
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant=0000, grant_id=00, busy=0, timeout=0.
  - Reset mid-grant drops grant to 0000 on that same edge. Requests are re-arbitrated from ptr=0.
- States: IDLE, GRANT, RELEASE. All outputs are registered.
- Arbitration (IDLE or RELEASE, en=1, req!=0):
  - Winner = first set bit of req, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: state=GRANT, grant_id=winner, grant=dec(winner), busy=1, hold_cnt=0, ptr=winner+1 (mod 4, 3 wraps to 0).
  - Latency: req sampled at edge N gives grant visible after edge N+1, i.e. one cycle.
- IDLE with en=0 or req=0000: stays in IDLE, grant=0000, ptr unchanged.
- GRANT, leave at the next edge if any of the following holds:
  - (a) done=1;
  - (b) req[grant_id]=0, meaning the owner withdrew;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, which also gives timeout=1 for exactly one cycle.
  - Leaving means: state=RELEASE, grant=0000, busy=0, grant_id held.
  - Otherwise hold_cnt increments and grant stays unchanged.
- Simultaneous release conditions in GRANT: done, withdrawal and timeout on the same edge → RELEASE. timeout pulses only if (c) is true and both (a) and (b) are false.
- RELEASE: grant=0000 for exactly one cycle (bus turnaround). It arbitrates like IDLE:
  - if a winner exists → GRANT next edge;
  - else → IDLE.
  - Back-to-back owners therefore see exactly one idle grant cycle.
- en=0 during GRANT: the current grant continues to normal release. The following RELEASE → IDLE, with no new grant.
- Fairness:
  - The just-served requester gets lowest priority next.
  - With all four requesting continuously and done pulsed every grant, the grant order is 0,1,2,3,0,...
  - Worst-case wait is 3 × (MAX_HOLD+1) cycles.
- Requests from non-owners during GRANT are ignored until RELEASE.
- done outside GRANT has no effect.
- Invariant: grant is 0000 or exactly one-hot; it is never one-hot in IDLE or RELEASE.

Decomposition:
- Shared package/header holds:
  - state encodings: ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - NUM_REQ=4.
- Sub-module: two_to_four_Dec instantiated for one-hot decode.
  - In: next-winner index; En: next-state==GRANT.
  - Out is registered into grant.
- Priority search is a small combinational function in this module; no further sub-modules.

Test Plan:
- Reset with req=1111, en=1: after deassert, the first grant is 0001 one cycle later, grant_id=0; rst mid-grant → grant=0000 on the next edge.
- req=1111 held, done pulsed on the 3rd GRANT cycle of each owner → grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- req=0100 only, MAX_HOLD=4, done never asserted:
  - grant=0100 for 4 cycles;
  - timeout=1 for 1 cycle coincident with grant=0000;
  - then re-grant 0100 after one RELEASE cycle.
- Owner 1 granted, req drops to 0000 on cycle 2 → RELEASE → IDLE, grant=0000, busy=0, ptr=2 (next req=1111 grants 0100).
- en=0 while owner 3 holds: owner finishes on done; then grant stays 0000 with req=1111 until en=1. The next grant is 0001, since ptr wrapped 3→0.
- done and timeout on the same edge (MAX_HOLD=2, done on 2nd cycle) → RELEASE with timeout=0.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encodings,
// requester count and the rotating priority search.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Returns {found, index} of the first set request starting at ptr.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_dec.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
// Purely combinational, no handshake.
module two_to_four_Dec (
  input  logic [1:0] In,
  input  logic       En,
  output logic [3:0] Out
);

  always_comb begin
    Out = 4'b0000;
    if (En) Out[In] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold/release handshake, hold timeout
// and one turnaround cycle between owners; one-cycle request-to-grant latency.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [1:0]       grant_id_nxt;
  logic             timeout_nxt;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       dec_idx;
  logic             dec_en;
  logic [3:0]       dec_out;
  logic             owner_gone;
  logic             hold_last;

  assign {win_vld, win_idx} = rr_pick(req, ptr);
  assign owner_gone = ~req[grant_id];
  assign hold_last  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_nxt     = hold_cnt;
    grant_id_nxt = grant_id;
    timeout_nxt  = 1'b0;
    dec_idx      = grant_id;
    case (state)
      ST_GRANT: begin
        // Other requesters are not looked at until the owner lets go.
        if (done || owner_gone || hold_last) begin
          state_nxt   = ST_RELEASE;
          timeout_nxt = hold_last && !done && !owner_gone;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        if (en && win_vld) begin
          state_nxt    = ST_GRANT;
          grant_id_nxt = win_idx;
          dec_idx      = win_idx;
          ptr_nxt      = win_idx + 2'd1;
          hold_nxt     = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign dec_en = (state_nxt == ST_GRANT);

  two_to_four_Dec u_dec (
    .In  (dec_idx),
    .En  (dec_en),
    .Out (dec_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      grant    <= 4'b0000;
      grant_id <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      grant    <= dec_out;
      grant_id <= grant_id_nxt;
      busy     <= dec_en;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Vector-table bench for rr_arbiter_4 (MAX_HOLD=4): expected outputs are queued
// when each input vector is driven and compared one edge later.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(5)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } vec_t;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic e, input logic [3:0] q, input logic d,
                     input logic [3:0] g, input logic [1:0] id, input logic b, input logic t);
    vec_t v;
    v = '{rst: r, en: e, req: q, done: d, g: g, id: id, b: b, t: t};
    tbl.push_back(v);
  endtask

  task automatic step(input string name, input vec_t v);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst  = v.rst;
    en   = v.en;
    req  = v.req;
    done = v.done;
    sb.push_back('{g: v.g, id: v.id, b: v.b, t: v.t});
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    got = '{g: grant, id: grant_id, b: busy, t: timeout};
    checks++;
    if (got !== x) begin
      errors++;
      $display("FAIL %s: grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
               name, grant, grant_id, busy, timeout, x.g, x.id, x.b, x.t);
    end
    checks++;
    if (!$onehot0(grant) || (busy !== (|grant))) begin
      errors++;
      $display("FAIL %s_onehot: grant=%b busy=%b, expected one-hot-or-zero grant with busy=|grant",
               name, grant, busy);
    end
  endtask

  initial begin
    // reset with all requesting, then first grant, then reset mid-grant
    add(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    // rotation, done on the third grant cycle of each owner
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(0, 1, 4'b1111, 1, 4'b0000, 1, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b1111, 1, 4'b0000, 2, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 1, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 1, 4'b1111, 1, 4'b0000, 3, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    // owner 0 withdraws; requester 2 alone runs into the hold timeout
    add(0, 1, 4'b0100, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0000, 2, 0, 1);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    // done coincident with the timeout edge: no timeout pulse
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 1, 4'b0100, 1, 4'b0000, 2, 0, 0);
    // owner 1 withdraws on its second cycle -> RELEASE -> IDLE, ptr=2
    add(0, 1, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 1, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 1, 0, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 1, 0, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 1, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0100, 2, 1, 0);
    // en=0 while owner 3 holds; ptr wraps to 0
    add(0, 1, 4'b1111, 1, 4'b0000, 2, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 0, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 0, 4'b1111, 1, 4'b0000, 3, 0, 0);
    add(0, 0, 4'b1111, 0, 4'b0000, 3, 0, 0);
    add(0, 0, 4'b1111, 0, 4'b0000, 3, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1, 0);
    // done outside GRANT is ignored
    add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b1000, 0, 4'b1000, 3, 1, 0);
    // withdrawal on the timeout edge: no timeout pulse
    add(0, 1, 4'b1000, 0, 4'b1000, 3, 1, 0);
    add(0, 1, 4'b1000, 0, 4'b1000, 3, 1, 0);
    add(0, 1, 4'b1000, 0, 4'b1000, 3, 1, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 3, 0, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 3, 0, 0);

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // hand sequence: en=0 from reset, then enable, grant, and reset mid-grant
    step("hs_rst",      '{1, 0, 4'b1111, 0, 4'b0000, 2'd0, 0, 0});
    step("hs_en0_a",    '{0, 0, 4'b1111, 0, 4'b0000, 2'd0, 0, 0});
    step("hs_en0_b",    '{0, 0, 4'b1010, 1, 4'b0000, 2'd0, 0, 0});
    step("hs_en1",      '{0, 1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0});
    step("hs_ignore",   '{0, 1, 4'b1111, 0, 4'b0010, 2'd1, 1, 0});
    step("hs_midreset", '{1, 1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0});
    step("hs_rearb",    '{0, 1, 4'b1110, 0, 4'b0010, 2'd1, 1, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
